// File: rtl/sum_stationary_pkg.sv
// Shared types and sizing helpers for the sum_stationary engine and its driver.
// Keeps C_DATA_WIDTH and the engine timeout in one place.
package sum_stationary_pkg;

    typedef enum logic [1:0] {
        S_LOAD,
        S_FEED,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam int TIMEOUT_MULT = 4;

    function automatic int c_data_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int timeout_cycles(input int n);
        return TIMEOUT_MULT * n;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_buffer.sv
// N x N operand store: row-indexed write, row or column (transposed) read.
// The read port is purely combinational from the stored registers.
module operand_buffer
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter bit TRANSPOSE  = 1'b0,
    localparam int IW        = idx_width(N)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data [N],
    input  logic [IW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data [N]
);

    logic [DATA_WIDTH-1:0] mem [N][N];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    mem[i][j] <= '0;
        end else if (wr_en) begin
            for (int j = 0; j < N; j++)
                mem[wr_idx][j] <= wr_data[j];
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++)
            rd_data[k] = TRANSPOSE ? mem[k][rd_idx] : mem[rd_idx][k];
    end

endmodule

// File: rtl/sum_stationary_driver.sv
// Load/feed/wait/drain controller wrapped around the sum_stationary engine.
// One shared counter walks load beats, feed beats and drained result rows.
module sum_stationary_driver
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = c_data_width(DATA_WIDTH, N)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    ld_valid_i,
    output logic                    ld_ready_o,
    input  logic [DATA_WIDTH-1:0]   ld_a_i [N],
    input  logic [DATA_WIDTH-1:0]   ld_b_i [N],
    output logic                    eng_reset_o,
    output logic                    eng_valid_o,
    output logic [DATA_WIDTH-1:0]   eng_a_o [N],
    output logic [DATA_WIDTH-1:0]   eng_b_o [N],
    input  logic                    eng_valid_i,
    input  logic [C_DATA_WIDTH-1:0] eng_c_i [N*N],
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [C_DATA_WIDTH-1:0] res_data_o [N],
    output logic                    res_last_o,
    output logic                    err_o
);

    localparam int CW = idx_width(N);
    localparam int WW = idx_width(timeout_cycles(N));

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q;
    logic [WW-1:0]           wait_q;
    logic                    eng_reset_q;
    logic                    err_q;
    logic [C_DATA_WIDTH-1:0] c_q [N][N];
    logic [DATA_WIDTH-1:0]   a_col [N];
    logic [DATA_WIDTH-1:0]   b_row [N];

    logic ld_fire, res_fire, last_cnt, timeout, capture;

    assign ld_fire  = (state_q == S_LOAD) && ld_valid_i;
    assign res_fire = (state_q == S_DRAIN) && res_ready_i;
    assign last_cnt = (cnt_q == CW'(N - 1));
    assign timeout  = (wait_q == WW'(timeout_cycles(N) - 1));
    assign capture  = (state_q == S_WAIT) && eng_valid_i;

    operand_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .N(N), .TRANSPOSE(1'b1)
    ) u_buf_a (
        .clk_i(clk_i), .reset_i(reset_i),
        .wr_en(ld_fire), .wr_idx(cnt_q), .wr_data(ld_a_i),
        .rd_idx(cnt_q), .rd_data(a_col)
    );

    operand_buffer #(
        .DATA_WIDTH(DATA_WIDTH), .N(N), .TRANSPOSE(1'b0)
    ) u_buf_b (
        .clk_i(clk_i), .reset_i(reset_i),
        .wr_en(ld_fire), .wr_idx(cnt_q), .wr_data(ld_b_i),
        .rd_idx(cnt_q), .rd_data(b_row)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_LOAD;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (ld_valid_i && last_cnt) state_d = S_FEED;
            S_FEED:  if (last_cnt) state_d = S_WAIT;
            S_WAIT:  if (eng_valid_i) state_d = S_DRAIN;
                     else if (timeout) state_d = S_LOAD;
            S_DRAIN: if (res_ready_i && last_cnt) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // eng_reset_q powers up high so the engine sees one clear edge after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            wait_q      <= '0;
            eng_reset_q <= 1'b1;
            err_q       <= 1'b0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    c_q[i][j] <= '0;
        end else begin
            eng_reset_q <= (state_q == S_WAIT) && (eng_valid_i || timeout);
            if (state_q == S_WAIT && !eng_valid_i && timeout)
                err_q <= 1'b1;
            if (ld_fire || state_q == S_FEED || res_fire)
                cnt_q <= last_cnt ? '0 : cnt_q + 1'b1;
            if (state_q == S_WAIT) wait_q <= wait_q + 1'b1;
            else                   wait_q <= '0;
            if (capture) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        c_q[i][j] <= eng_c_i[i*N+j];
            end
        end
    end

    always_comb begin
        ld_ready_o  = (state_q == S_LOAD);
        eng_valid_o = (state_q == S_FEED);
        res_valid_o = (state_q == S_DRAIN);
        res_last_o  = (state_q == S_DRAIN) && last_cnt;
        eng_reset_o = eng_reset_q;
        err_o       = err_q;
        for (int k = 0; k < N; k++) begin
            eng_a_o[k]    = (state_q == S_FEED) ? a_col[k] : '0;
            eng_b_o[k]    = (state_q == S_FEED) ? b_row[k] : '0;
            res_data_o[k] = (state_q == S_DRAIN) ? c_q[cnt_q][k] : '0;
        end
    end

endmodule

// File: doc/sum_stationary_driver.md
# sum_stationary_driver

Front-end/back-end controller for the `sum_stationary` systolic matrix multiplier. It accepts matrices A and B row by row over a valid/ready load port and buffers them. It then drives the engine's skew-free column/row beat stream, waits for the engine's `valid_o`, and captures the N×N result. Finally it clears the engine and returns C row by row over a valid/ready result port.

## Interface
- `DATA_WIDTH`, 8, operand width (unsigned)
- `N`, 4, matrix dimension
- `C_DATA_WIDTH`, `2*DATA_WIDTH + $clog2(N)`, result element width; must equal the engine's value
- `clk_i`  in  1  clock
- `reset_i`  in  1  reset, asynchronous, active-high
- `ld_valid_i`  in  1  load beat valid
- `ld_ready_o`  out  1  driver can accept a load beat
- `ld_a_i[N]`  in  N×DATA_WIDTH  row k of A (beat k)
- `ld_b_i[N]`  in  N×DATA_WIDTH  row k of B (beat k)
- `eng_reset_o`  out  1  synchronous clear to engine `reset_i`
- `eng_valid_o`  out  1  to engine `valid_i`
- `eng_a_o[N]`  out  N×DATA_WIDTH  to engine `a_i`
- `eng_b_o[N]`  out  N×DATA_WIDTH  to engine `b_i`
- `eng_valid_i`  in  1  from engine `valid_o`
- `eng_c_i[N*N]`  in  N*N×C_DATA_WIDTH  from engine `c_o`; element i*N+j is C[i][j]
- `res_valid_o`  out  1  result row valid
- `res_ready_i`  in  1  result consumer ready
- `res_data_o[N]`  out  N×C_DATA_WIDTH  row i of C
- `res_last_o`  out  1  marks row N-1
- `err_o`  out  1  sticky engine-timeout flag

## Operation
- FSM states are LOAD, FEED, WAIT and DRAIN. Reset state is LOAD.
- LOAD:
  - `ld_ready_o`=1.
  - Each `ld_valid_i && ld_ready_o` beat writes row k of A and row k of B, with k = 0..N-1.
  - After beat N-1, go to FEED.
- FEED:
  - Lasts exactly N cycles, t = 0..N-1, with `eng_valid_o`=1.
  - `eng_a_o[k]` = A[k][t] (column t of A, which is a transpose read).
  - `eng_b_o[k]` = B[t][k].
  - Outside FEED, `eng_valid_o`=0 and `eng_a_o`/`eng_b_o`=0.
- WAIT:
  - A wait counter runs.
  - In the first cycle with `eng_valid_i`=1, capture all of `eng_c_i` into the result buffer, assert `eng_reset_o` for exactly the next cycle, and go to DRAIN.
  - If `eng_valid_i` has not arrived after 4N WAIT cycles, set `err_o`, pulse `eng_reset_o` for one cycle and return to LOAD. No result is produced.
- DRAIN:
  - `res_valid_o`=1 and `res_data_o` = captured row r, with r = 0..N-1.
  - `res_last_o` = (r == N-1).
  - r advances on `res_valid_o && res_ready_i`. The handshake on row N-1 returns the FSM to LOAD.
  - While `res_ready_i`=0, data is held stable.
- Arithmetic: the driver never modifies result data. It is captured and emitted at full `C_DATA_WIDTH`, with no truncation or sign handling.
- `ld_valid_i` outside LOAD is ignored; no beat is stored.
- `eng_valid_i` outside WAIT is ignored. This includes the cycle(s) before the engine clear takes effect.
- `err_o` clears only on `reset_i`.

## Timing
- Reset values:
  - `ld_ready_o`=1, `eng_reset_o`=1, `eng_valid_o`=0, `eng_a_o`/`eng_b_o`=0
  - `res_valid_o`=0, `res_last_o`=0, `res_data_o`=0, `err_o`=0
  - Operand buffers, result buffer, beat/row counters and wait counter all =0.
- `eng_reset_o` is held 1 during reset and through the first clock edge after deassertion, then it drops to 0. This guarantees an engine clear at power-up.
- A nominal engine asserts `eng_valid_i` 2N-1 cycles after the last FEED cycle, i.e. 3N-2 cycles after FEED beat 0.
- Minimum job latency, from the last load handshake to the first `res_valid_o`:
  - N cycles of FEED, plus
  - 2N-1 cycles until `eng_valid_i`, plus
  - 1 capture cycle.
- State transitions occur on the clock edge. Outputs are registered or decoded from state registers only; there are no combinational paths from `res_ready_i` or `ld_valid_i` to outputs.
- `reset_i` asserted mid-operation (any state): immediately return to reset values; a partially loaded or partially drained job is discarded.

## Structure
- Shared package `sum_stationary_pkg`:
  - FSM state enum typedef.
  - Localparam helper for `C_DATA_WIDTH`, shared with `sum_stationary`.
  - Timeout constant (4N).
- Sub-module `operand_buffer`:
  - N×N register array with row-indexed write.
  - Column-indexed (transposed) or row-indexed read selected by parameter.
  - Instantiated once for A (column read) and once for B (row read).

## Test plan
N=4, DATA_WIDTH=8, a bench pairs the driver with the real `sum_stationary`.
- A=I, B rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> C rows equal B rows. `eng_valid_o` is high for exactly 4 cycles and `eng_valid_i` arrives 7 cycles after the last FEED cycle.
- All A,B elements 255 -> every C element 260100 (0x3F804, fits 18 bits). `res_last_o` is high only on row 3.
- Back-to-back jobs with all-ones A,B -> both jobs return all elements 4, never 8, which proves the `eng_reset_o` clear works.
- `res_ready_i` held low 3 cycles on row 1 -> row 1 data stable, r unchanged, `ld_ready_o`=0 throughout DRAIN.
- `reset_i` pulsed during FEED beat 2 -> all outputs return to reset values. The following job (A=I, B=I) returns the identity.
- Engine model that never raises valid -> `err_o`=1 after 16 WAIT cycles, a one-cycle `eng_reset_o` pulse, and `ld_ready_o`=1 on the next cycle.
